// File: rtl/case_1_sdiv_seq_26s_12s_pkg.sv
// rtl/case_1_sdiv_seq_26s_12s_pkg.sv - shared types, widths and magnitude helper for the signed divider
// Contents: state_e (FSM encoding), default operand widths, abs_u magnitude conversion.
package case_1_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int DIVIDEND_W_DEF = 26;
  localparam int DIVISOR_W_DEF  = 12;

  // Magnitude of a sign-extended operand. Callers narrow the result with a size
  // cast; the most negative operand maps to 2^(W-1), which still fits in W bits.
  function automatic logic [31:0] abs_u(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    return u[31] ? (~u + 32'd1) : u;
  endfunction

endpackage

// File: rtl/case_1_sdiv_seq_26s_12s_if.sv
// rtl/case_1_sdiv_seq_26s_12s_if.sv - operand/result handshake bundle for the signed divider
// master: drives in_valid/dividend/divisor/out_ready; slave (the divider): drives in_ready,
// out_valid, quotient, remainder, dbz, ovf.
interface case_1_sdiv_seq_26s_12s_if
  import case_1_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) ();

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DIVIDEND_W-1:0] quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         dbz;
  logic                         ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz, ovf
  );

endinterface

// File: rtl/case_1_sdiv_seq_26s_12s_step.sv
// rtl/case_1_sdiv_seq_26s_12s_step.sv - one combinational restoring-division step on magnitudes
// Ports: rem_in (partial remainder), dmsb (next dividend bit), dvs (|divisor|) ->
//        rem_out (next partial remainder), qbit (quotient bit).
module case_1_div_step #(
  parameter int DIVISOR_W = 12
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 dmsb,
  input  logic [DIVISOR_W-1:0] dvs,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 qbit
);

  // One extra bit so the shifted remainder can be compared before it is reduced.
  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] diff;

  always_comb begin
    shifted = {rem_in, dmsb};
    diff    = shifted - {1'b0, dvs};
    qbit    = (shifted >= {1'b0, dvs});
    // After a successful subtract the result is below |divisor|, so the top bit is zero.
    rem_out = DIVISOR_W'(qbit ? diff : shifted);
  end

endmodule

// File: rtl/case_1_sdiv_seq_26s_12s.sv
// rtl/case_1_sdiv_seq_26s_12s.sv - sequential signed divider, one quotient bit per clock
// Ports: ap_clk, ap_rst_n (synchronous, active-low); bus (slave): operands in via
//        in_valid/in_ready, quotient/remainder/dbz/ovf out via out_valid/out_ready.
module case_1_sdiv_seq_26s_12s
  import case_1_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  case_1_sdiv_seq_26s_12s_if.slave  bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  if (ID < 0 || DIVIDEND_W > 31 || DIVISOR_W >= DIVIDEND_W) begin : g_cfg_check
    $error("case_1_sdiv_seq_26s_12s: unsupported configuration");
  end

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Holds |dividend| on entry; quotient bits shift in at the bottom as dividend bits leave the top.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  dbz_cap_q, dbz_cap_d;
  logic                  ovf_cap_q, ovf_cap_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;
  logic                  out_valid_q, out_valid_d;

  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_qbit;

  case_1_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (rem_q),
    .dmsb    (dvd_q[DIVIDEND_W-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .qbit    (step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_cap_d   = dbz_cap_q;
    ovf_cap_d   = ovf_cap_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dvd_d     = DIVIDEND_W'(abs_u(32'(bus.dividend)));
          dvs_d     = DIVISOR_W'(abs_u(32'(bus.divisor)));
          neg_quo_d = bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
          neg_rem_d = bus.dividend[DIVIDEND_W-1];
          dbz_cap_d = (bus.divisor == '0);
          ovf_cap_d = (bus.dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (bus.divisor == '1);
          rem_d     = '0;
          cnt_d     = CNT_W'(DIVIDEND_W - 1);
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DIVIDEND_W-2:0], step_qbit};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        if (dbz_cap_q) begin
          quotient_d  = '1;
          remainder_d = '0;
        end else if (ovf_cap_q) begin
          quotient_d  = {1'b1, {(DIVIDEND_W-1){1'b0}}};
          remainder_d = '0;
        end else begin
          quotient_d  = neg_quo_q ? (~dvd_q + DIVIDEND_W'(1)) : dvd_q;
          remainder_d = neg_rem_q ? (~rem_q + DIVISOR_W'(1)) : rem_q;
        end
        dbz_d       = dbz_cap_q;
        ovf_d       = ovf_cap_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_cap_q   <= 1'b0;
      ovf_cap_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_cap_q   <= dbz_cap_d;
      ovf_cap_q   <= ovf_cap_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_case_1_sdiv_seq_26s_12s.sv
// tb/tb_case_1_sdiv_seq_26s_12s.sv - self-checking bench for the sequential signed divider
module tb_case_1_sdiv_seq_26s_12s;

  localparam int DW  = 26;
  localparam int VW  = 12;
  localparam int LAT = DW + 1;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  case_1_sdiv_seq_26s_12s_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

  case_1_sdiv_seq_26s_12s #(.ID(1), .DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: results from plain signed arithmetic, visible only once the
  // fixed latency after acceptance has elapsed, held until consumed.
  typedef enum int {M_IDLE, M_BUSY, M_DONE} m_state_e;
  m_state_e     m_st   = M_IDLE;
  int           m_age  = 0;
  logic [DW-1:0] m_pq, m_q = '0;
  logic [VW-1:0] m_pr, m_r = '0;
  logic          m_pdbz, m_dbz = 1'b0;
  logic          m_povf, m_ovf = 1'b0;

  task automatic model_div(input longint a, input longint b,
                           output logic [DW-1:0] q, output logic [VW-1:0] r,
                           output logic z, output logic o);
    z = 1'b0;
    o = 1'b0;
    if (b == 0) begin
      q = '1; r = '0; z = 1'b1;
    end else if (a == -(longint'(1) << (DW - 1)) && b == -1) begin
      q = DW'(a); r = '0; o = 1'b1;
    end else begin
      q = DW'(a / b);
      r = VW'(a % b);
    end
  endtask

  initial begin : compare
    longint a, b;
    @(posedge ap_clk);
    forever begin
      @(negedge ap_clk);
      chk("in_ready",  64'(bus.in_ready),  64'(m_st == M_IDLE));
      chk("out_valid", 64'(bus.out_valid), 64'(m_st == M_DONE));
      chk("quotient",  64'($unsigned(bus.quotient)),  64'(m_q));
      chk("remainder", 64'($unsigned(bus.remainder)), 64'(m_r));
      chk("dbz",       64'(bus.dbz), 64'(m_dbz));
      chk("ovf",       64'(bus.ovf), 64'(m_ovf));
      if (!ap_rst_n) begin
        m_st = M_IDLE; m_q = '0; m_r = '0; m_dbz = 1'b0; m_ovf = 1'b0;
      end else begin
        case (m_st)
          M_IDLE: if (bus.in_valid) begin
            a = bus.dividend;
            b = bus.divisor;
            model_div(a, b, m_pq, m_pr, m_pdbz, m_povf);
            m_age = 0;
            m_st  = M_BUSY;
          end
          M_BUSY: begin
            m_age++;
            if (m_age == LAT) begin
              m_st = M_DONE; m_q = m_pq; m_r = m_pr; m_dbz = m_pdbz; m_ovf = m_povf;
            end
          end
          default: if (bus.out_ready) m_st = M_IDLE;
        endcase
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_op(input logic signed [DW-1:0] dvd, input logic signed [VW-1:0] dvs,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er,
                        input logic edbz, input logic eovf, input int hold);
    int lat;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.in_valid = 1'b1;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = VW'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    chk("lit_valid_seen", 64'(bus.out_valid), 64'd1);
    chk("lit_latency", 64'(lat), 64'(LAT));
    chk("lit_quotient", 64'($unsigned(bus.quotient)), 64'(eq));
    chk("lit_remainder", 64'($unsigned(bus.remainder)), 64'(er));
    chk("lit_dbz", 64'(bus.dbz), 64'(edbz));
    chk("lit_ovf", 64'(bus.ovf), 64'(eovf));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.dividend = DW'($urandom);
      bus.divisor  = VW'($urandom);
      @(posedge ap_clk); #1;
    end
    if (hold > 0) begin
      chk("lit_hold_quotient", 64'($unsigned(bus.quotient)), 64'(eq));
      chk("lit_hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("lit_hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge ap_clk); #1;
    bus.out_ready = 1'b0;
    chk("lit_in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("lit_valid_dropped", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin : stimulus
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    ap_rst_n      = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_quotient", 64'($unsigned(bus.quotient)), 64'd0);
    chk("rst_remainder", 64'($unsigned(bus.remainder)), 64'd0);

    run_op(26'sd1000, 12'sd7, 26'd142, 12'd6, 1'b0, 1'b0, 0);
    run_op(-26'sd1000, 12'sd7, 26'h3FFFF72, 12'hFFA, 1'b0, 1'b0, 0);
    run_op(26'sd1000, -12'sd7, 26'h3FFFF72, 12'h006, 1'b0, 1'b0, 0);
    run_op(26'sd5, 12'sd0, 26'h3FFFFFF, 12'h000, 1'b1, 1'b0, 0);
    run_op(26'sh2000000, 12'shFFF, 26'h2000000, 12'h000, 1'b0, 1'b1, 0);
    run_op(26'sh2000000, 12'sd7, 26'd62315374, 12'hFFE, 1'b0, 1'b0, 0);
    run_op(26'sd33554431, 12'sh800, 26'd67092481, 12'h7FF, 1'b0, 1'b0, 0);
    run_op(26'sd1000, 12'sd7, 26'd142, 12'd6, 1'b0, 1'b0, 10);
    run_op(26'sd12345, -12'sd3, 26'd67104749, 12'd0, 1'b0, 1'b0, 0);

    bus.dividend = 26'sd100000;
    bus.divisor  = 12'sd3;
    bus.in_valid = 1'b1;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_quotient", 64'($unsigned(bus.quotient)), 64'd0);
    repeat (30) @(posedge ap_clk);
    #1;
    chk("midrst_no_result", 64'(bus.out_valid), 64'd0);
    run_op(26'sd26, 12'sd5, 26'd5, 12'd1, 1'b0, 1'b0, 0);

    repeat (3) @(posedge ap_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
